// File: rtl/alu181_serial.sv
// Nibble-serial 74181-style ALU: one 4-bit slice per clock, LSB first, registered ripple carry.
// Optional overflow output enabled by defining ALU181_OVF_EN.
module alu181_serial #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             zero,
`ifdef ALU181_OVF_EN
   output logic             ovf,
`endif
   output logic             aeqb
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_s;
   logic             r_m;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_f;
   logic             r_cout;
   logic             r_zero;
   logic             r_aeqb;
`ifdef ALU181_OVF_EN
   logic             r_ovf;
   logic [3:0]       w_low;
`endif

   logic [3:0]       w_na;
   logic [3:0]       w_nb;
   logic [3:0]       w_x;
   logic [3:0]       w_y;
   logic [3:0]       w_lf;
   logic [4:0]       w_sum;
   logic [3:0]       w_nib;
   logic [WIDTH-1:0] w_f_next;
   logic             w_last;

   assign w_na   = r_a[{r_idx, 2'b00} +: 4];
   assign w_nb   = r_b[{r_idx, 2'b00} +: 4];
   assign w_last = (r_idx == IDXW'(NIB - 1));

   // Arithmetic operands are built per nibble from the captured words, so the
   // registered carry makes the multi-cycle sum identical to a full-width add.
   always_comb begin
      w_x = '0;
      w_y = '0;
      case (r_s)
         4'b0000: begin w_x = w_na;          w_y = '0;            end
         4'b0001: begin w_x = w_na | w_nb;   w_y = '0;            end
         4'b0010: begin w_x = w_na | ~w_nb;  w_y = '0;            end
         4'b0011: begin w_x = '0;            w_y = '1;            end
         4'b0100: begin w_x = w_na;          w_y = w_na & ~w_nb;  end
         4'b0101: begin w_x = w_na | w_nb;   w_y = w_na & ~w_nb;  end
         4'b0110: begin w_x = w_na;          w_y = ~w_nb;         end
         4'b0111: begin w_x = w_na & ~w_nb;  w_y = '1;            end
         4'b1000: begin w_x = w_na;          w_y = w_na & w_nb;   end
         4'b1001: begin w_x = w_na;          w_y = w_nb;          end
         4'b1010: begin w_x = w_na | ~w_nb;  w_y = w_na & w_nb;   end
         4'b1011: begin w_x = w_na & w_nb;   w_y = '1;            end
         4'b1100: begin w_x = w_na;          w_y = w_na;          end
         4'b1101: begin w_x = w_na | w_nb;   w_y = w_na;          end
         4'b1110: begin w_x = w_na | ~w_nb;  w_y = w_na;          end
         default: begin w_x = w_na;          w_y = '1;            end
      endcase
   end

   always_comb begin
      w_lf = '0;
      case (r_s)
         4'b0000: w_lf = ~w_na;
         4'b0001: w_lf = ~(w_na | w_nb);
         4'b0010: w_lf = ~w_na & w_nb;
         4'b0011: w_lf = '0;
         4'b0100: w_lf = ~(w_na & w_nb);
         4'b0101: w_lf = ~w_nb;
         4'b0110: w_lf = w_na ^ w_nb;
         4'b0111: w_lf = w_na & ~w_nb;
         4'b1000: w_lf = ~w_na | w_nb;
         4'b1001: w_lf = ~(w_na ^ w_nb);
         4'b1010: w_lf = w_nb;
         4'b1011: w_lf = w_na & w_nb;
         4'b1100: w_lf = '1;
         4'b1101: w_lf = w_na | ~w_nb;
         4'b1110: w_lf = w_na | w_nb;
         default: w_lf = w_na;
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, r_carry};
   assign w_nib = r_m ? w_lf : w_sum[3:0];

`ifdef ALU181_OVF_EN
   // Carry into the top bit of the slice; only meaningful on the last nibble.
   assign w_low = {1'b0, w_x[2:0]} + {1'b0, w_y[2:0]} + {3'b000, r_carry};
`endif

   always_comb begin
      w_f_next = r_f;
      w_f_next[{r_idx, 2'b00} +: 4] = w_nib;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = RUN;
         end
         RUN: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_m     <= 1'b0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_f     <= '0;
         r_cout  <= 1'b0;
         r_zero  <= 1'b0;
         r_aeqb  <= 1'b0;
`ifdef ALU181_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_s     <= s;
                  r_m     <= m;
                  r_idx   <= '0;
                  r_carry <= cin & ~m;
               end
            end
            RUN: begin
               r_f     <= w_f_next;
               r_carry <= r_m ? 1'b0 : w_sum[4];
               r_idx   <= r_idx + IDXW'(1);
               if (w_last) begin
                  r_cout <= r_m ? 1'b0 : w_sum[4];
                  r_zero <= (w_f_next == '0);
                  r_aeqb <= &w_f_next;
`ifdef ALU181_OVF_EN
                  r_ovf  <= r_m ? 1'b0 : (w_low[3] ^ w_sum[4]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign f    = r_f;
   assign cout = r_cout;
   assign zero = r_zero;
   assign aeqb = r_aeqb;
`ifdef ALU181_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_alu181_serial.sv
// Self-checking bench for alu181_serial (WIDTH=16): vector table, random ops vs. a
// full-width reference model, plus backpressure and mid-operation reset sequences.
module tb_alu181_serial;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   s;
   logic         m;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] f;
   logic         cout;
   logic         zero;
   logic         aeqb;
`ifdef ALU181_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   alu181_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .s         (s),
      .m         (m),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f         (f),
      .cout      (cout),
      .zero      (zero),
`ifdef ALU181_OVF_EN
      .ovf       (ovf),
`endif
      .aeqb      (aeqb)
   );

   typedef struct packed {
      logic [W-1:0] f;
      logic         co;
      logic         z;
      logic         eq;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   s;
      logic         m;
      logic         cin;
      exp_t         e;
   } vec_t;

   vec_t tbl[15];
   exp_t scb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk_exp(input logic [W-1:0] ff, input logic co, input logic ov);
      exp_t r;
      r.f  = ff;
      r.co = co;
      r.z  = (ff == '0);
      r.eq = &ff;
      r.ov = ov;
      return r;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [3:0] vs,
                               input logic vm, input logic vc, input logic [W-1:0] ef,
                               input logic eco, input logic eov);
      vec_t v;
      v.a = va; v.b = vb; v.s = vs; v.m = vm; v.cin = vc;
      v.e = mk_exp(ef, eco, eov);
      return v;
   endfunction

   // Whole-word reference: full-width add, overflow from carry into the MSB.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [3:0] ms,
                                  input logic mm, input logic mc);
      logic [W-1:0] x, y, lf;
      logic [W:0]   sum;
      logic [W-1:0] lo;
      x = '0; y = '0; lf = '0;
      case (ms)
         4'h0: begin lf = ~ma;          x = ma;        y = '0;        end
         4'h1: begin lf = ~(ma | mb);   x = ma | mb;   y = '0;        end
         4'h2: begin lf = ~ma & mb;     x = ma | ~mb;  y = '0;        end
         4'h3: begin lf = '0;           x = '0;        y = '1;        end
         4'h4: begin lf = ~(ma & mb);   x = ma;        y = ma & ~mb;  end
         4'h5: begin lf = ~mb;          x = ma | mb;   y = ma & ~mb;  end
         4'h6: begin lf = ma ^ mb;      x = ma;        y = ~mb;       end
         4'h7: begin lf = ma & ~mb;     x = ma & ~mb;  y = '1;        end
         4'h8: begin lf = ~ma | mb;     x = ma;        y = ma & mb;   end
         4'h9: begin lf = ~(ma ^ mb);   x = ma;        y = mb;        end
         4'hA: begin lf = mb;           x = ma | ~mb;  y = ma & mb;   end
         4'hB: begin lf = ma & mb;      x = ma & mb;   y = '1;        end
         4'hC: begin lf = '1;           x = ma;        y = ma;        end
         4'hD: begin lf = ma | ~mb;     x = ma | mb;   y = ma;        end
         4'hE: begin lf = ma | mb;      x = ma | ~mb;  y = ma;        end
         default: begin lf = ma;        x = ma;        y = '1;        end
      endcase
      sum = {1'b0, x} + {1'b0, y} + (W+1)'(mc);
      lo  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + W'(mc);
      if (mm) return mk_exp(lf, 1'b0, 1'b0);
      return mk_exp(sum[W-1:0], sum[W], lo[W-1] ^ sum[W]);
   endfunction

   task automatic compare_out(input string tag);
      exp_t e;
      if (scb.size() == 0) begin
         chk({tag, "_scb_underflow"}, 32'd1, 32'd0);
         return;
      end
      e = scb.pop_front();
      chk({tag, "_f"},    32'(f),    32'(e.f));
      chk({tag, "_cout"}, 32'(cout), 32'(e.co));
      chk({tag, "_zero"}, 32'(zero), 32'(e.z));
      chk({tag, "_aeqb"}, 32'(aeqb), 32'(e.eq));
`ifdef ALU181_OVF_EN
      chk({tag, "_ovf"},  32'(ovf),  32'(e.ov));
`endif
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [3:0] vs, input logic vm, input logic vc, input exp_t e);
      int g;
      int lat;
      a = va; b = vb; s = vs; m = vm; cin = vc; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 20) begin tick(); g++; end
      if (!in_ready) begin
         chk({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      tick();
      in_valid = 1'b0;
      scb.push_back(e);
      a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      if (!out_valid) begin
         chk({tag, "_out_valid_timeout"}, 32'd0, 32'd1);
         void'(scb.pop_front());
         return;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(NIB));
      compare_out(tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] held;
      int g;
      exp_t e;

      tbl[0]  = mk(16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
      tbl[1]  = mk(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      tbl[2]  = mk(16'h0005, 16'h0003, 4'h6, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      tbl[3]  = mk(16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0);
      tbl[4]  = mk(16'hF0F0, 16'hFF00, 4'hC, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      tbl[5]  = mk(16'h1234, 16'h5678, 4'h3, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      tbl[6]  = mk(16'h1234, 16'h5678, 4'h3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      tbl[7]  = mk(16'hABCD, 16'h1111, 4'h3, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
      tbl[8]  = mk(16'h8001, 16'h0000, 4'hC, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1);
      tbl[9]  = mk(16'h1234, 16'h0000, 4'h0, 1'b1, 1'b0, 16'hEDCB, 1'b0, 1'b0);
      tbl[10] = mk(16'hFFFF, 16'h0000, 4'h0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      tbl[11] = mk(16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      tbl[12] = mk(16'h0F0F, 16'h00FF, 4'hB, 1'b1, 1'b0, 16'h000F, 1'b0, 1'b0);
      tbl[13] = mk(16'h00F0, 16'h0030, 4'h7, 1'b0, 1'b0, 16'h00BF, 1'b1, 1'b0);
      tbl[14] = mk(16'h0F00, 16'h00F0, 4'hE, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
      tick(); tick();
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_f",         32'(f),         32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_zero",      32'(zero),      32'd0);
      chk("rst_aeqb",      32'(aeqb),      32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 15; i++)
         do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cin, tbl[i].e);

      // Backpressure: DONE held with in_valid asserted must neither change f nor accept.
      a = 16'h1111; b = 16'h2222; s = 4'h9; m = 1'b0; cin = 1'b0; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 20) begin tick(); g++; end
      tick();
      a = 16'h5555; b = 16'h5555;
      g = 0;
      while (!out_valid && g < 20) begin tick(); g++; end
      chk("bp_reach_done", 32'(out_valid), 32'd1);
      held = 16'h3333;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_f_%0d", k),         32'(f),         32'(held));
         chk($sformatf("bp_in_ready_%0d", k),  32'(in_ready),  32'd0);
         chk($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready",  32'(in_ready),  32'd1);
      tick();
      chk("bp_no_second_capture", 32'(in_ready), 32'd1);

      // Reset in the middle of RUN discards the operation.
      a = 16'hAAAA; b = 16'h5555; s = 4'h9; m = 1'b0; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("runrst_out_valid", 32'(out_valid), 32'd0);
      chk("runrst_in_ready",  32'(in_ready),  32'd1);
      chk("runrst_f",         32'(f),         32'd0);
      rst = 1'b0;
      tick();
      do_op("post_rst", 16'h4321, 16'h1111, 4'h9, 1'b0, 1'b0, mk_exp(16'h5432, 1'b0, 1'b0));

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra, rb;
         logic [3:0]   rs;
         logic         rm, rc;
         ra = W'($urandom); rb = W'($urandom); rs = 4'($urandom);
         rm = 1'($urandom); rc = 1'($urandom);
         e = model(ra, rb, rs, rm, rc);
         do_op($sformatf("rnd%0d", i), ra, rb, rs, rm, rc, e);
      end

      chk("scb_empty", 32'(scb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu181_serial.md
Name: alu181_serial

Overview:
- Parametrised, multi-cycle successor to the 4-bit 74181-style logic unit.
- Supports logic mode (M=1) and arithmetic mode (M=0) over a WIDTH-bit operand.
- Processes one 4-bit nibble per clock, LSB nibble first, with a registered ripple carry between nibbles.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIB, WIDTH/4, derived local constant (nibble count); not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- s  input  4  function select
- m  input  1  1 = logic mode, 0 = arithmetic mode
- cin  input  1  active-high carry-in (adds 1 in arithmetic mode)
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- f  output  WIDTH  result
- cout  output  1  carry out of MSB
- zero  output  1  f == 0
- aeqb  output  1  f == all ones (74181 A=B semantics)

Behaviour:
- Reset: synchronous, active-high.
  - Sampled at a clk edge, reset forces state IDLE, in_ready=1, out_valid=0, f=0, cout=0, zero=0, aeqb=0, internal carry=0.
  - Reset overrides any handshake in the same cycle; asserting it mid-RUN or in DONE discards the operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, s, m, cin; set nibble index=0 and carry=cin (forced 0 if m=1); go to RUN.
  - RUN: in_ready=0. Each cycle, compute nibble[idx] and write it into the f register; carry <= nibble carry-out; idx++. After nibble NIB-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. f, cout, zero and aeqb hold stable until out_valid&&out_ready; then go to IDLE.
  - There is no bypass: a new bundle is accepted only in IDLE, so back-to-back throughput is one op per NIB+2 cycles.
- Latency: handshake at edge T, first nibble at T+1, out_valid asserted from edge T+NIB (WIDTH=16: 4 cycles).
- f is updated nibble-by-nibble during RUN. Its value is defined only while out_valid=1.
- Logic mode (m=1), bitwise, carry ignored, cout=0:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B
  - 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A
- Arithmetic mode (m=0): F = X + Y + cin, computed modulo 2^WIDTH; cout is the carry out of bit WIDTH-1. Per select value:
  - 0000 A+0; 0001 (A|B)+0; 0010 (A|~B)+0; 0011 0+all-ones (-1)
  - 0100 A+(A&~B); 0101 (A|B)+(A&~B); 0110 A+~B (A-B-1); 0111 (A&~B)+all-ones
  - 1000 A+(A&B); 1001 A+B; 1010 (A|~B)+(A&B); 1011 (A&B)+all-ones
  - 1100 A+A; 1101 (A|B)+A; 1110 (A|~B)+A; 1111 A+all-ones
- X and Y are formed per nibble from the captured operands, so the carry chain is exact across nibbles.
- zero and aeqb are computed from the complete f when entering DONE.
- Input changes outside the accept cycle have no effect.

Optional Feature:
- Macro: ALU181_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit).
  - In arithmetic mode, ovf = carry into bit WIDTH-1 XOR cout; ovf=0 in logic mode.
  - Reset value 0; ovf is valid and held with out_valid.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, m=0, s=1001, a=0x1234, b=0x0FFF, cin=0 -> f=0x2233, cout=0, zero=0; out_valid first high 4 cycles after accept.
- m=0, s=1001, a=0xFFFF, b=0x0001, cin=0 -> f=0x0000, cout=1, zero=1 (carry ripples through all 4 nibbles).
- m=0, s=0110, a=0x0005, b=0x0003, cin=1 -> f=0x0002, cout=1.
- m=1, s=0110, a=0xF0F0, b=0xFF00, cin=1 -> f=0x0FF0, cout=0. Then m=1, s=1100 -> f=0xFFFF, aeqb=1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> f stable, in_ready=0, no second capture.
  - Assert rst during RUN -> next cycle out_valid=0, in_ready=1, f=0.
- With ALU181_OVF_EN: m=0, s=1001, a=0x7FFF, b=0x0001, cin=0 -> f=0x8000, ovf=1, cout=0.
